fifo_ctrl_auto: RTL
===================

Name: fifo_ctrl_auto

Overview:
Parametrised successor to the board-level FIFO test block. It combines a single-clock FIFO with a rising-edge command front end for push-buttons, a tick-paced auto-drain mode, occupancy and threshold flags, and sticky overflow/underflow error reporting with clear. It sits between the board inputs (switches, buttons, divided-tick enable) and the BCD display path, all on the 100 MHz board clock. Pacing comes through tick_en, so there is no derived clock.

Parameters:
WL, 8, data word width in bits (1..32)
DEPTH, 4, number of entries; must be a power of 2, at least 2
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  asynchronous, active-low reset (RST=0 resets)
din  in  WL  write data, sampled on the accepted write cycle
wr_btn  in  1  write button level; rising edge = one write request
rd_btn  in  1  read button level; rising edge = one read request
auto  in  1  level; when 1, each tick_en pulse issues one read request
tick_en  in  1  single-cycle pacing strobe from the divider
err_clr  in  1  synchronous clear of the sticky error flags
dout  out  WL  last word read; holds its value between reads
rd_valid  out  1  one-cycle pulse, aligned with a dout update
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
almost_full  out  1  count >= DEPTH-AF_MARGIN
almost_empty  out  1  count <= AE_MARGIN
ovf  out  1  sticky: a write was attempted while full
udf  out  1  sticky: a read was attempted while empty
error  out  1  ovf | udf

Behaviour:
- Reset (RST=0, asynchronous):
  - Cleared: pointers, count, dout, rd_valid, ovf, udf, and both edge-detect registers.
  - Resulting outputs: empty=1, almost_empty=1, all other flags 0.
  - Memory contents are not reset. Reset mid-operation discards all stored data.
- Edge detect:
  - wr_req = wr_btn & ~wr_btn_q. wr_btn_q is registered every cycle.
  - rd_req = (rd_btn & ~rd_btn_q) | (auto & tick_en).
  - A held button gives exactly one request.
  - A button edge coinciding with an auto tick counts as a single read.
  - Inputs are assumed already synchronised and debounced upstream.
- Write accepted iff wr_req & (~full | rd_ok).
  - On accept: mem[wptr] <= din; wptr increments modulo DEPTH.
- Read accepted (rd_ok) iff rd_req & ~empty.
  - On accept: dout <= mem[rptr] on the same edge; rptr increments modulo DEPTH; rd_valid=1 the following cycle for exactly one cycle.
  - Read latency is one clock from the request edge.
- Count update:
  - count +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous write and read:
  - When full: both are accepted, count stays at DEPTH, no ovf.
  - When empty: the write is accepted, the read is rejected, udf sets, and count becomes 1. There is no fall-through.
- Errors:
  - ovf sets on wr_req when full and the read is not accepted.
  - udf sets on a rejected rd_req.
  - Both are sticky until err_clr=1 or reset.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - A rejected operation changes no pointer, count, or dout.
- Flags: full, empty, almost_full, and almost_empty are decoded combinationally from registered count, so they are glitch-free relative to CLK.
- Pointer width is $clog2(DEPTH); wrap-around is natural binary overflow.

Test Plan:
- Reset then idle, DEPTH=4 -> count=0, empty=1, almost_empty=1, dout=0, error=0.
- Write edges with din=0x11, 0x22, 0x33, 0x44, then a fifth edge with 0x55 -> count=4, full=1, almost_full asserted from count=3, ovf=1, and 0x55 is not stored.
- Four rd_btn edges -> dout sequence 0x11, 0x22, 0x33, 0x44, each with a one-cycle rd_valid one clock after its edge; empty=1. A fifth edge sets udf=1 with dout held at 0x44.
- Hold wr_btn high for 10 cycles with din=0xA5 -> exactly one write, count=1.
- When full, wr and rd edges in the same cycle -> count stays 4, the oldest word is read, the new word is appended, and there is no ovf. Repeat 6 times to exercise pointer wrap with data order preserved.
- auto=1, tick_en pulsed every 5 cycles with 3 stored words -> three reads at the tick cycles, then udf=1. err_clr=1 -> error=0. Assert RST=0 mid-stream -> count=0 immediately, asynchronously.

Source files
------------

// File: rtl/fifo_ctrl_auto.sv
// Single-clock FIFO with push-button edge commands, tick-paced auto-drain,
// occupancy/threshold flags and sticky overflow/underflow reporting.
module fifo_ctrl_auto #(
  parameter int WL        = 8,
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WL-1:0]            din,
  input  logic                     wr_btn,
  input  logic                     rd_btn,
  input  logic                     auto,
  input  logic                     tick_en,
  input  logic                     err_clr,
  output logic [WL-1:0]            dout,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     ovf,
  output logic                     udf,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WL-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_btn_q;
  logic          rd_btn_q;
  logic          wr_req;
  logic          rd_req;
  logic          wr_ok;
  logic          rd_ok;
  logic          ovf_set;
  logic          udf_set;

  assign wr_req = wr_btn & ~wr_btn_q;
  assign rd_req = (rd_btn & ~rd_btn_q) | (auto & tick_en);

  // A read on the same edge frees a slot, so a write into a full FIFO is legal then.
  assign rd_ok  = rd_req & ~empty;
  assign wr_ok  = wr_req & (~full | rd_ok);

  assign ovf_set = wr_req & ~wr_ok;
  assign udf_set = rd_req & ~rd_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(DEPTH - AF_MARGIN));
  assign almost_empty = (count <= CW'(AE_MARGIN));
  assign error        = ovf | udf;

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_btn_q <= 1'b0;
      rd_btn_q <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      dout     <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      wr_btn_q <= wr_btn;
      rd_btn_q <= rd_btn;
      rd_valid <= rd_ok;
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set takes priority over a same-cycle clear.
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end

endmodule
